encoder_32to5_seq: RTL and testbench
====================================

// Module: encoder_32to5_seq
// PURPOSE
//  Sequential 32-to-5 encoder; the inverse of decoder_5to32. Captures a 32-bit
//  request vector on Load and emits the 5-bit index of every set bit, one per
//  handshake, in priority order. Signals Done with the number of codes emitted.
//  It sits upstream of decoder_5to32 so that any multi-hot vector can be
//  serialised into addresses and rebuilt on the other side.
// PARAMETERS
//  N_IN          32  width of the request vector
//  W_OUT         5   code width, equal to $clog2(N_IN)
//  PRIORITY_LSB  1   1: lowest set index is emitted first; 0: highest set index first
// PORTS
//  Clk     in   1      clock; all logic updates on the rising edge
//  Reset   in   1      synchronous, active-high reset
//  Enable  in   1      0: the FSM and all registers hold (stall); 1: run
//  D       in   32     request vector; sampled only when Load is accepted
//  Load    in   1      start strobe; accepted only in IDLE with Enable=1
//  Ready   in   1      downstream accepts A this cycle
//  A       out  5      registered code of the current set bit
//  Valid   out  1      A holds a valid code
//  Busy    out  1      a frame is in progress (states EMIT and DONE)
//  Done    out  1      one-cycle pulse that ends a frame
//  Count   out  6      codes emitted in the frame; 0..32; valid while Done=1
// BEHAVIOUR
//  Reset: every output is 0 (A=0, Valid=0, Busy=0, Done=0, Count=0); pending reg P=0;
//   state goes to IDLE. Reset wins over Enable and over every other input.
//  States: IDLE, EMIT, DONE. All registers are clocked and Enable-qualified.
//  IDLE: on Load&&Enable, P<=D and Count<=0.
//   If D!=0: A<=enc(D), Valid<=1, go to EMIT. If D==0: go to DONE.
//   Latency is one cycle from Load to the first Valid.
//  EMIT: a transfer happens when Valid&&Ready&&Enable.
//   On a transfer: P<=P with bit A cleared, and Count<=Count+1.
//   If the remaining P is nonzero, A<=enc(remaining) and Valid stays 1.
//   If the remaining P is zero, Valid<=0 and go to DONE.
//   With Ready held high, throughput is one code per cycle.
//   While Valid&&!Ready, A and Valid must hold stable.
//  DONE: Done=1 for exactly one cycle with Count final, then go to IDLE.
//   Busy falls in the same transition. Done rises one cycle after the last transfer.
//  enc(): index of the lowest set bit, or of the highest if PRIORITY_LSB=0. Never applied to 0.
//  Boundaries:
//   Load outside IDLE is ignored, and P is not disturbed.
//   Ready while Valid=0 is ignored.
//   D=0 gives a frame with no Valid; Done one cycle after Load, with Count=0.
//   D=all-ones gives 32 codes; Count=32 and does not wrap (6-bit counter).
//   Enable=0 mid-frame freezes every register, including a pending Done.
//   Reset mid-frame aborts the frame: Valid=0 at the next edge, no Done pulse.
//  Every set bit is emitted exactly once per frame: no loss, no duplication.
// STRUCTURE
//  Shared package (enc_pkg):
//   N_IN=32, W_OUT=5, W_CNT=6
//   state localparams: IDLE=2'd0, EMIT=2'd1, DONE=2'd2
//  Sub-module prio_enc_32to5: combinational, with outputs idx[4:0] and any.
//   Parameter PRIORITY_LSB. Instantiate it once on the next-P value.
//  Top level: FSM, P register, A/Valid output registers, Count counter.
// TESTING
//  T1: Reset=1 for 2 cycles, then release -> all outputs 0, FSM in IDLE.
//  T2: D=32'h0000_0001, Load, Ready=1 -> next cycle A=0 with Valid=1;
//      Done the cycle after; Count=1.
//  T3: D=32'h8000_0006, Ready=1 -> A=1,2,31 on consecutive cycles;
//      Done then follows with Count=3. With PRIORITY_LSB=0 -> A=31,2,1.
//  T4: D=32'h0000_0000, Load -> Valid never rises; Done one cycle later; Count=0.
//  T5: D=32'h0000_00F0, Ready toggled 1,0,0,1,0,1,1 -> A is stable through stalls;
//      the codes 4,5,6,7 each transfer exactly once. Load pulsed mid-frame is ignored.
//  T6: D=32'hFFFF_FFFF, Ready=1 -> codes 0..31, Count=32. Feed the codes to
//      decoder_5to32 (Enable=1); the OR of its outputs equals D.
//      Repeat with Reset asserted after 10 codes -> Valid=0 next cycle, no Done.
//      Repeat with Enable=0 for 3 cycles -> all outputs frozen.

Source files
------------

// File: rtl/encoder_32to5_seq_pkg.sv
// Shared constants and FSM state type for the sequential 32-to-5 encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enc_pkg;

    localparam int N_IN  = 32;
    localparam int W_OUT = 5;
    localparam int W_CNT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/encoder_32to5_seq_prio_enc.sv
// Combinational priority encoder: index of the lowest (or highest) set request bit.
// Latency: zero cycles, purely combinational.
// Backpressure: none; any=0 flags an all-zero request, in which case idx is 0.
module prio_enc_32to5
    import enc_pkg::*;
#(
    parameter bit PRIORITY_LSB = 1'b1
) (
    input  logic [N_IN-1:0]  req,
    output logic [W_OUT-1:0] idx,
    output logic             any
);

    // Scan so that the winning bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        if (PRIORITY_LSB) begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (req[i]) begin
                    idx = W_OUT'(i);
                    any = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (req[i]) begin
                    idx = W_OUT'(i);
                    any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/encoder_32to5_seq.sv
// Serialises a multi-hot request vector into one 5-bit index per handshake, then pulses Done with the code count.
// Latency: first code one cycle after Load; one code per cycle with Ready high; Done one cycle after the last transfer.
// Backpressure: A/Valid hold while Valid && !Ready; Enable=0 freezes every register.
module encoder_32to5_seq
    import enc_pkg::*;
#(
    parameter bit PRIORITY_LSB = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [N_IN-1:0]  D,
    input  logic             Load,
    input  logic             Ready,
    output logic [W_OUT-1:0] A,
    output logic             Valid,
    output logic             Busy,
    output logic             Done,
    output logic [W_CNT-1:0] Count
);

    state_t            state;
    state_t            state_nxt;
    logic [N_IN-1:0]   p;
    logic [N_IN-1:0]   p_nxt;
    logic [W_CNT-1:0]  count_nxt;
    logic [N_IN-1:0]   cur_bit;
    logic [W_OUT-1:0]  a_nxt;
    logic              any_nxt;

    // One-hot mask of the code currently presented on A.
    assign cur_bit = {{(N_IN-1){1'b0}}, 1'b1} << A;

    // Next-state, next pending set and next count; a single encoder then looks at the next pending set.
    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        count_nxt = Count;
        case (state)
            IDLE: begin
                if (Load) begin
                    p_nxt     = D;
                    count_nxt = '0;
                    state_nxt = (D != '0) ? EMIT : DONE;
                end
            end
            EMIT: begin
                if (Valid && Ready) begin
                    p_nxt     = p & ~cur_bit;
                    count_nxt = Count + W_CNT'(1);
                    if (p_nxt == '0) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    prio_enc_32to5 #(
        .PRIORITY_LSB (PRIORITY_LSB)
    ) u_prio_enc (
        .req (p_nxt),
        .idx (a_nxt),
        .any (any_nxt)
    );

    // State register; a stall simply holds the current state, including DONE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else if (Enable) begin
            state <= state_nxt;
        end
    end

    // Datapath registers. A only moves when there is a new code to show, so it is stable through stalls.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            p     <= '0;
            A     <= '0;
            Valid <= 1'b0;
            Count <= '0;
        end else if (Enable) begin
            p     <= p_nxt;
            Count <= count_nxt;
            Valid <= (state_nxt == EMIT);
            if (any_nxt) begin
                A <= a_nxt;
            end
        end
    end

    assign Busy = (state == EMIT) || (state == DONE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_encoder_32to5_seq.sv
// Bench for encoder_32to5_seq: LSB-first and MSB-first instances share one stimulus stream.
// Latency: outputs sampled on the falling edge, after the rising-edge update.
// Backpressure: Ready and Enable are driven both by directed patterns and randomly.
module tb_encoder_32to5_seq;

    logic        clk = 1'b0;
    logic        reset, enable, load, ready;
    logic [31:0] d;

    logic [4:0]  a_l, a_m;
    logic        valid_l, valid_m, busy_l, busy_m, done_l, done_m;
    logic [5:0]  count_l, count_m;

    always #5 clk = ~clk;

    encoder_32to5_seq #(.PRIORITY_LSB(1'b1)) dut_lsb (
        .Clk(clk), .Reset(reset), .Enable(enable), .D(d), .Load(load), .Ready(ready),
        .A(a_l), .Valid(valid_l), .Busy(busy_l), .Done(done_l), .Count(count_l)
    );

    encoder_32to5_seq #(.PRIORITY_LSB(1'b0)) dut_msb (
        .Clk(clk), .Reset(reset), .Enable(enable), .D(d), .Load(load), .Ready(ready),
        .A(a_m), .Valid(valid_m), .Busy(busy_m), .Done(done_m), .Count(count_m)
    );

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: the codes still owed for the frame, in emission order, per priority.
    int          q_l[$];
    int          q_m[$];
    bit          done_pend = 1'b0;
    int          cnt_ref   = 0;
    logic [31:0] d_frame   = '0;
    logic [31:0] rb_l      = '0;
    logic [31:0] rb_m      = '0;
    logic        obs_v_l = 1'b0, obs_v_m = 1'b0;
    logic [4:0]  obs_a_l = '0, obs_a_m = '0;
    logic [31:0] rnd_d;
    int          rp[7] = '{1, 0, 0, 1, 0, 1, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic model_update();
        if (reset) begin
            q_l.delete();
            q_m.delete();
            done_pend = 1'b0;
            cnt_ref   = 0;
        end else if (enable) begin
            if (done_pend) begin
                done_pend = 1'b0;
            end else if (q_l.size() != 0) begin
                if (ready) begin
                    if (obs_v_l) rb_l |= 32'd1 << obs_a_l;
                    if (obs_v_m) rb_m |= 32'd1 << obs_a_m;
                    void'(q_l.pop_front());
                    void'(q_m.pop_front());
                    cnt_ref++;
                    if (q_l.size() == 0) done_pend = 1'b1;
                end
            end else if (load) begin
                d_frame = d;
                rb_l    = '0;
                rb_m    = '0;
                cnt_ref = 0;
                for (int i = 0; i < 32; i++)   if (d[i]) q_l.push_back(i);
                for (int i = 31; i >= 0; i--)  if (d[i]) q_m.push_back(i);
                if (q_l.size() == 0) done_pend = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        bit exp_valid;
        exp_valid = (q_l.size() != 0);
        obs_v_l = valid_l;
        obs_a_l = a_l;
        obs_v_m = valid_m;
        obs_a_m = a_m;
        check("valid_lsb", {31'd0, valid_l}, {31'd0, exp_valid});
        check("valid_msb", {31'd0, valid_m}, {31'd0, exp_valid});
        check("busy_lsb", {31'd0, busy_l}, {31'd0, exp_valid || done_pend});
        check("busy_msb", {31'd0, busy_m}, {31'd0, exp_valid || done_pend});
        check("done_lsb", {31'd0, done_l}, {31'd0, done_pend});
        check("done_msb", {31'd0, done_m}, {31'd0, done_pend});
        if (exp_valid) begin
            check("a_lsb", {27'd0, a_l}, q_l[0]);
            check("a_msb", {27'd0, a_m}, q_m[0]);
        end
        if (reset) begin
            check("a_rst", {27'd0, a_l}, 32'd0);
            check("count_rst", {26'd0, count_l}, 32'd0);
        end
        if (done_pend) begin
            check("count_lsb", {26'd0, count_l}, cnt_ref);
            check("count_msb", {26'd0, count_m}, cnt_ref);
            check("rebuild_lsb", rb_l, d_frame);
            check("rebuild_msb", rb_m, d_frame);
        end
    endtask

    task automatic cyc(input bit r, input bit en, input bit ld, input logic [31:0] dv, input bit rdy);
        reset  = r;
        enable = en;
        load   = ld;
        d      = dv;
        ready  = rdy;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic finish_frame(input int max_cycles);
        int n;
        n = 0;
        while ((q_l.size() != 0 || done_pend) && n < max_cycles) begin
            cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
            n++;
        end
        if (q_l.size() != 0 || done_pend) begin
            check("frame_timeout", 32'd1, 32'd0);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles, with Load asserted to show reset wins.
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);

        // Single bit, several set bits, empty vector.
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b1);
        finish_frame(40);
        cyc(1'b0, 1'b1, 1'b1, 32'h8000_0006, 1'b1);
        finish_frame(40);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1);
        finish_frame(5);

        // Ready toggling with a stray Load of a different vector mid-frame.
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_00F0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, (i == 2), 32'hFFFF_0000, rp[i][0]);
        end
        finish_frame(20);

        // All ones: 32 codes, count saturating the frame at 32.
        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        finish_frame(40);

        // All ones aborted by reset after ten codes: no Done may follow.
        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);

        // All ones with a three-cycle stall mid-frame.
        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 32'h0000_0005, 1'b1);
        finish_frame(50);

        // Stall while Done is pending: the pulse must stretch, not vanish.
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0002, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        finish_frame(5);

        // Random traffic: mixed densities, random Ready/Enable/Load, rare resets.
        for (int k = 0; k < 1500; k++) begin
            case ($urandom_range(0, 3))
                0:       rnd_d = 32'd0;
                1:       rnd_d = $urandom;
                2:       rnd_d = $urandom & $urandom & $urandom;
                default: rnd_d = 32'd1 << $urandom_range(0, 31);
            endcase
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 3) == 0), rnd_d, ($urandom_range(0, 2) != 0));
        end
        finish_frame(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
